// File: rtl/card_dealer_if.sv
// card_dealer_if
//
// Command channel between the game FSM (master) and the card dealer (slave).
//
// Handshake: a command transfers on a rising clock edge where
// cmd_valid && cmd_ready. The master holds cmd_valid and cmd stable until
// that edge. cmd_valid while cmd_ready is low is ignored. The slave answers
// every accepted command with exactly one of: a one-cycle done pulse when
// the work completes, or a one-cycle err pulse in the cycle after the edge
// when the command is rejected.
//
// Signals:
//   cmd_valid  master->slave  command strobe
//   cmd[2:0]   master->slave  0 SHUFFLE, 1 HOLE, 2 FLOP, 3 TURN, 4 RIVER
//   cmd_ready  slave->master  high only while the dealer is idle
//   busy       slave->master  high while a shuffle or deal is running
//   done       slave->master  one-cycle completion pulse
//   err        slave->master  one-cycle rejection pulse
`timescale 1ns/1ps
interface card_dealer_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd,
        output cmd_ready, busy, done, err
    );
endinterface

// File: rtl/card_dealer.sv
// card_dealer
//
// Holds a 52-card deck, shuffles it in place with an LFSR-driven
// Fisher-Yates pass (one swap per cycle) and deals cards one per cycle on
// command. A card is carried as its deck index: suit = idx % 4 (Spades,
// Hearts, Diamonds, Clubs), rank = idx / 4 (Two .. Ace).
//
// Configuration macro: DEALER_BURN_EN
//   defined   -> FLOP, TURN and RIVER each start with one burn step
//   undefined -> no burn steps
//
// Parameters:
//   SEED          LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   bus           card_dealer_if.slave command channel
//   player_cards  hole cards, [player][slot]
//   flop_card     three flop cards
//   turn_card     turn card
//   river_card    river card
//   hole_valid, flop_valid, turn_valid, river_valid
//                 set when the matching deal completes, cleared by SHUFFLE
//   o_dbg_state   current FSM state (IDLE=0, SHUFFLE=1, DEAL=2)
//   o_dbg_phase   current deal phase (HOLE=0 .. DONE=4)
`timescale 1ns/1ps
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset_n,
    card_dealer_if.slave    bus,
    output logic [5:0]      player_cards [2][2],
    output logic [5:0]      flop_card [3],
    output logic [5:0]      turn_card,
    output logic [5:0]      river_card,
    output logic            hole_valid,
    output logic            flop_valid,
    output logic            turn_valid,
    output logic            river_valid,
    output logic [1:0]      o_dbg_state,
    output logic [2:0]      o_dbg_phase
);

`ifdef DEALER_BURN_EN
    localparam bit BURN_EN = 1'b1;
`else
    localparam bit BURN_EN = 1'b0;
`endif

    // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_DEAL    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PH_HOLE  = 3'd0,
        PH_FLOP  = 3'd1,
        PH_TURN  = 3'd2,
        PH_RIVER = 3'd3,
        PH_DONE  = 3'd4
    } phase_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    phase_t      r_phase;
    logic [15:0] r_lfsr;
    logic [5:0]  r_deck [52];
    logic [5:0]  r_ptr;          // next deck position to deal from
    logic [5:0]  r_k;            // Fisher-Yates index, 51 down to 1
    logic [1:0]  r_step;         // step within the current deal
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [5:0]  r_player [2][2];
    logic [5:0]  r_flop [3];
    logic [5:0]  r_turn;
    logic [5:0]  r_river;
    logic        r_hole_valid;
    logic        r_flop_valid;
    logic        r_turn_valid;
    logic        r_river_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr_next;
    logic [11:0] w_prod;
    logic [5:0]  w_j;
    logic        w_accept;
    logic        w_deal_ok;
    logic        w_has_burn;
    logic        w_is_burn;
    logic [1:0]  w_slot;
    logic [1:0]  w_last_step;
    logic        w_last;
    logic [5:0]  w_card;

    // Right-shifting Galois LFSR: the bit shifted out selects the mask.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

    // j = (lfsr[5:0] * (k+1)) >> 6 maps a 6-bit random value onto 0..k
    // without a divider.
    assign w_prod = {6'd0, r_lfsr[5:0]} * {6'd0, r_k + 6'd1};
    assign w_j    = 6'(w_prod >> 6);

    assign w_accept  = bus.cmd_valid && r_ready;
    // Deal codes 1..4 line up with phases HOLE..RIVER shifted by one, so a
    // deal is in order exactly when cmd == phase + 1. DONE (4) never matches.
    assign w_deal_ok = (bus.cmd >= 3'd1) && (bus.cmd <= 3'd4) &&
                       (bus.cmd == (3'(r_phase) + 3'd1));

    // Street deals open with a burn when burns are enabled; the slot index
    // for the written card is then one behind the step counter.
    assign w_has_burn = BURN_EN && (r_phase != PH_HOLE);
    assign w_is_burn  = w_has_burn && (r_step == 2'd0);
    assign w_slot     = w_has_burn ? (r_step - 2'd1) : r_step;
    assign w_card     = r_deck[r_ptr];

    always_comb begin
        w_last_step = 2'd0;
        case (r_phase)
            PH_HOLE:  w_last_step = 2'd3;
            PH_FLOP:  w_last_step = BURN_EN ? 2'd3 : 2'd2;
            PH_TURN:  w_last_step = BURN_EN ? 2'd1 : 2'd0;
            PH_RIVER: w_last_step = BURN_EN ? 2'd1 : 2'd0;
            default:  w_last_step = 2'd0;
        endcase
    end

    assign w_last = (r_step == w_last_step);

    // ------------------------------------------------------------------
    // Main FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= PH_HOLE;
            r_lfsr        <= SEED_EFF;
            r_ptr         <= 6'd0;
            r_k           <= 6'd0;
            r_step        <= 2'd0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_turn        <= 6'd0;
            r_river       <= 6'd0;
            r_hole_valid  <= 1'b0;
            r_flop_valid  <= 1'b0;
            r_turn_valid  <= 1'b0;
            r_river_valid <= 1'b0;
            for (int i = 0; i < 52; i++) begin
                r_deck[i] <= 6'(i);
            end
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < 2; s++) begin
                    r_player[p][s] <= 6'd0;
                end
            end
            for (int f = 0; f < 3; f++) begin
                r_flop[f] <= 6'd0;
            end
        end else begin
            r_lfsr <= w_lfsr_next;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.cmd == 3'd0) begin
                            r_state <= ST_SHUFFLE;
                            r_k     <= 6'd51;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else if (w_deal_ok) begin
                            r_state <= ST_DEAL;
                            r_step  <= 2'd0;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_SHUFFLE: begin
                    // When j == k both writes carry the same value.
                    r_deck[r_k] <= r_deck[w_j];
                    r_deck[w_j] <= r_deck[r_k];
                    if (r_k == 6'd1) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_ready       <= 1'b1;
                        r_done        <= 1'b1;
                        r_ptr         <= 6'd0;
                        r_phase       <= PH_HOLE;
                        r_hole_valid  <= 1'b0;
                        r_flop_valid  <= 1'b0;
                        r_turn_valid  <= 1'b0;
                        r_river_valid <= 1'b0;
                    end else begin
                        r_k <= r_k - 6'd1;
                    end
                end

                ST_DEAL: begin
                    r_ptr <= r_ptr + 6'd1;
                    if (!w_is_burn) begin
                        case (r_phase)
                            // Hole cards alternate players: slot bit 0 picks
                            // the player, bit 1 the card slot.
                            PH_HOLE: r_player[w_slot[0]][w_slot[1]] <= w_card;
                            PH_FLOP: begin
                                case (w_slot)
                                    2'd0:    r_flop[0] <= w_card;
                                    2'd1:    r_flop[1] <= w_card;
                                    default: r_flop[2] <= w_card;
                                endcase
                            end
                            PH_TURN:  r_turn  <= w_card;
                            PH_RIVER: r_river <= w_card;
                            default: ;
                        endcase
                    end

                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        case (r_phase)
                            PH_HOLE: begin
                                r_hole_valid <= 1'b1;
                                r_phase      <= PH_FLOP;
                            end
                            PH_FLOP: begin
                                r_flop_valid <= 1'b1;
                                r_phase      <= PH_TURN;
                            end
                            PH_TURN: begin
                                r_turn_valid <= 1'b1;
                                r_phase      <= PH_RIVER;
                            end
                            PH_RIVER: begin
                                r_river_valid <= 1'b1;
                                r_phase       <= PH_DONE;
                            end
                            default: r_phase <= PH_DONE;
                        endcase
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    assign player_cards = r_player;
    assign flop_card    = r_flop;
    assign turn_card    = r_turn;
    assign river_card   = r_river;

    assign hole_valid  = r_hole_valid;
    assign flop_valid  = r_flop_valid;
    assign turn_valid  = r_turn_valid;
    assign river_valid = r_river_valid;

    assign o_dbg_state = r_state;
    assign o_dbg_phase = r_phase;

endmodule

// File: tb/tb_card_dealer.sv
`timescale 1ns/1ps
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;
`ifdef DEALER_BURN_EN
    localparam bit BURN = 1'b1;
`else
    localparam bit BURN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if bus ();

    logic [5:0] player_cards [2][2];
    logic [5:0] flop_card [3];
    logic [5:0] turn_card;
    logic [5:0] river_card;
    logic       hole_valid, flop_valid, turn_valid, river_valid;
    logic [1:0] dbg_state;
    logic [2:0] dbg_phase;

    card_dealer #(.SEED(SEED)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .player_cards (player_cards),
        .flop_card    (flop_card),
        .turn_card    (turn_card),
        .river_card   (river_card),
        .hole_valid   (hole_valid),
        .flop_valid   (flop_valid),
        .turn_valid   (turn_valid),
        .river_valid  (river_valid),
        .o_dbg_state  (dbg_state),
        .o_dbg_phase  (dbg_phase)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running model LFSR: reset to SEED, one step per clock.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    int         m_deck [52];
    int         m_ptr;
    int         m_phase;           // 0 hole .. 4 all dealt
    int         m_p [2][2];
    int         m_flop [3];
    int         m_turn, m_river;
    bit         m_hv, m_fv, m_tv, m_rv;
    logic [5:0] exp_q [$];         // cards expected from the current deal, in deal order

    function automatic void model_reset();
        for (int i = 0; i < 52; i++) m_deck[i] = i;
        m_ptr = 0; m_phase = 0;
        for (int p = 0; p < 2; p++) for (int s = 0; s < 2; s++) m_p[p][s] = 0;
        for (int f = 0; f < 3; f++) m_flop[f] = 0;
        m_turn = 0; m_river = 0;
        m_hv = 0; m_fv = 0; m_tv = 0; m_rv = 0;
        exp_q.delete();
    endfunction

    // Fisher-Yates with j = (r * (k+1)) >> 6, r = low 6 bits of the LFSR
    // value current during each swap cycle; the first swap sees the value
    // right after the accepting edge.
    function automatic void model_shuffle(input logic [15:0] l0);
        logic [15:0] cur;
        int j, t;
        cur = l0;
        for (int k = 51; k >= 1; k--) begin
            j = (int'(cur[5:0]) * (k + 1)) >> 6;
            t = m_deck[k]; m_deck[k] = m_deck[j]; m_deck[j] = t;
            cur = lfsr_step(cur);
        end
        m_ptr = 0; m_phase = 0;
        m_hv = 0; m_fv = 0; m_tv = 0; m_rv = 0;
    endfunction

    function automatic int take();
        int c;
        c = m_deck[m_ptr];
        m_ptr++;
        exp_q.push_back(6'(c));
        return c;
    endfunction

    // Deals one street from the model deck; returns the number of steps.
    function automatic int model_deal(input int c);
        int start;
        start = m_ptr;
        case (c)
            1: begin
                for (int s = 0; s < 4; s++) m_p[s % 2][s / 2] = take();
                m_hv = 1;
            end
            2: begin
                if (BURN) m_ptr++;
                for (int f = 0; f < 3; f++) m_flop[f] = take();
                m_fv = 1;
            end
            3: begin
                if (BURN) m_ptr++;
                m_turn = take();
                m_tv = 1;
            end
            default: begin
                if (BURN) m_ptr++;
                m_river = take();
                m_rv = 1;
            end
        endcase
        m_phase++;
        return m_ptr - start;
    endfunction

    // Scoreboard: the freshly written outputs must match the queued cards.
    task automatic score_deal(input int c);
        logic [5:0] e;
        case (c)
            1: for (int s = 0; s < 4; s++) begin
                e = exp_q.pop_front();
                check("sb_hole", player_cards[s % 2][s / 2], e);
            end
            2: for (int f = 0; f < 3; f++) begin
                e = exp_q.pop_front();
                check("sb_flop", flop_card[f], e);
            end
            3: begin e = exp_q.pop_front(); check("sb_turn", turn_card, e); end
            default: begin e = exp_q.pop_front(); check("sb_river", river_card, e); end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                check({tag, "_player"}, player_cards[p][s], m_p[p][s]);
        for (int f = 0; f < 3; f++) check({tag, "_flop"}, flop_card[f], m_flop[f]);
        check({tag, "_turn"}, turn_card, m_turn);
        check({tag, "_river"}, river_card, m_river);
        check({tag, "_valids"}, {hole_valid, flop_valid, turn_valid, river_valid},
              {m_hv, m_fv, m_tv, m_rv});
    endtask

    // ---------------- driver ----------------
    task automatic do_cmd(input logic [2:0] c);
        bit          legal;
        logic [15:0] lfsr_e;
        int          n, cyc, busy_cnt;
        legal = (c == 3'd0) || (c >= 3'd1 && c <= 3'd4 && int'(c) - 1 == m_phase);
        @(negedge clk);
        check("ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        @(posedge clk);
        #1 lfsr_e = m_lfsr;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'($urandom_range(0, 7));
        if (!legal) begin
            check("err_pulse", bus.err, 1'b1);
            check("err_busy", bus.busy, 1'b0);
            check("err_ready", bus.cmd_ready, 1'b1);
            @(negedge clk);
            check("err_one_cycle", bus.err, 1'b0);
            check_outputs("err_keep");
            return;
        end
        check("acc_err", bus.err, 1'b0);
        check("acc_ready_low", bus.cmd_ready, 1'b0);
        if (c == 3'd0) begin
            model_shuffle(lfsr_e);
            n = 51;
        end else begin
            n = model_deal(int'(c));
        end
        cyc = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 200) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", bus.done, 1'b1);
        check("done_latency", cyc, n);
        check("busy_cycles", busy_cnt, n);
        check("done_busy_low", bus.busy, 1'b0);
        check("done_ready", bus.cmd_ready, 1'b1);
        if (c != 3'd0) score_deal(int'(c));
        check_outputs("after_cmd");
        @(negedge clk);
        check("done_one_cycle", bus.done, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sorted-deck expectations, written out from the card encoding.
    task automatic check_sorted_hole();
        check("sorted_p0s0", player_cards[0][0], 6'd0);   // Two of Spades
        check("sorted_p1s0", player_cards[1][0], 6'd1);   // Two of Hearts
        check("sorted_p0s1", player_cards[0][1], 6'd2);   // Two of Diamonds
        check("sorted_p1s1", player_cards[1][1], 6'd3);   // Two of Clubs
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          dups, c;
        logic [5:0]  dealt [9];

        bus.cmd_valid = 1'b0;
        bus.cmd       = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", bus.cmd_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check_outputs("rst");
        reset_n = 1'b1;

        // Sorted deal
        do_cmd(3'd1);
        check_sorted_hole();
        do_cmd(3'd2);
        do_cmd(3'd3);
        do_cmd(3'd4);
        check("sorted_flop0", flop_card[0], BURN ? 6'd5 : 6'd4);
        check("sorted_flop1", flop_card[1], BURN ? 6'd6 : 6'd5);
        check("sorted_flop2", flop_card[2], BURN ? 6'd7 : 6'd6);
        check("sorted_turn", turn_card, BURN ? 6'd9 : 6'd7);
        check("sorted_river", river_card, BURN ? 6'd11 : 6'd8);

        // All streets dealt: deals err, shuffle accepted and clears valids
        do_cmd(3'd1);
        do_cmd(3'd0);
        check("shuf_river_valid", river_valid, 1'b0);

        // Out-of-order and illegal commands
        do_cmd(3'd1);
        do_cmd(3'd3);
        check("ooo_flop_valid", flop_valid, 1'b0);
        check("ooo_turn_valid", turn_valid, 1'b0);
        do_cmd(3'd6);
        do_cmd(3'd2);
        check("ooo_flop_ok", flop_valid, 1'b1);

        // Shuffle then full deal: nine distinct cards
        do_cmd(3'd0);
        for (int s = 1; s <= 4; s++) do_cmd(3'(s));
        dealt[0] = player_cards[0][0]; dealt[1] = player_cards[1][0];
        dealt[2] = player_cards[0][1]; dealt[3] = player_cards[1][1];
        dealt[4] = flop_card[0]; dealt[5] = flop_card[1]; dealt[6] = flop_card[2];
        dealt[7] = turn_card;    dealt[8] = river_card;
        dups = 0;
        for (int a = 0; a < 9; a++)
            for (int b = a + 1; b < 9; b++)
                if (dealt[a] == dealt[b]) dups++;
        check("distinct_cards", dups, 0);

        // Reset in the middle of a shuffle
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd       = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy_before", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_busy_rst", bus.busy, 1'b0);
        check("mid_ready_rst", bus.cmd_ready, 1'b1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        dups = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) dups++;
        end
        check("mid_no_done", dups, 0);
        do_cmd(3'd1);
        check_sorted_hole();

        // Randomized command stream
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) c = 0;
            else c = $urandom_range(1, 7);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_cmd(3'(c));
            if ($urandom_range(0, 19) == 0) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit in case the DUT wedges somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
